// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues one instruction-memory request at a time and registers the fetched word for decode
module fetch_stage #(
   parameter int DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'hBFC00000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  PCSrc,
   input  logic [DATA_WIDTH-1:0] PCTarget,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_valid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] pc,
   output logic [DATA_WIDTH-1:0] pc_plus4,
   output logic                  instr_valid
);
   localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h00000013);
   localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);
   typedef enum logic [1:0] {IDLE, BUSY, DROP} state_t;
   state_t state, state_nx;
   logic [DATA_WIDTH-1:0] fetch_pc;
   logic capture, consume;
   assign imem_addr = fetch_pc;
   // request strobe, capture/consume events and next state; a redirect turns an outstanding fetch stale
   always_comb begin
      imem_req = (state == IDLE) && !PCSrc && !(instr_valid && stall);
      capture  = (state == BUSY) && imem_valid && !PCSrc;
      consume  = instr_valid && !stall;
      state_nx = (state == IDLE) ? (imem_req ? BUSY : IDLE) :
                 imem_valid ? IDLE :
                 (state == BUSY && PCSrc) ? DROP : state;
   end
   // fetch state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= state_nx;
   end
   // fetch address: redirect wins, otherwise advance after each accepted word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) fetch_pc <= RESET_PC;
      else if (PCSrc) fetch_pc <= {PCTarget[DATA_WIDTH-1:2], 2'b00};
      else if (capture) fetch_pc <= fetch_pc + FOUR;
   end
   // output register to decode; a redirect flushes it to a NOP but keeps pc/pc_plus4
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instr       <= NOP;
         pc          <= '0;
         pc_plus4    <= '0;
         instr_valid <= 1'b0;
      end else if (PCSrc) begin
         instr       <= NOP;
         instr_valid <= 1'b0;
      end else if (capture) begin
         instr       <= imem_rdata;
         pc          <= fetch_pc;
         pc_plus4    <= fetch_pc + FOUR;
         instr_valid <= 1'b1;
      end else if (consume) begin
         instr_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table, directed corner sequences and random traffic against a queue-based reference
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [31:0] RPC = 32'hBFC00000;
   logic clk = 1'b0;
   logic rst, stall, PCSrc, imem_req, imem_valid, instr_valid;
   logic [31:0] PCTarget, imem_addr, imem_rdata, instr, pc, pc_plus4;
   int total = 0, bad = 0;
   fetch_stage #(.DATA_WIDTH(32), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .stall(stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
      .instr(instr), .pc(pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid)
   );
   always #5 clk = ~clk;
   typedef struct {logic [31:0] a; bit stale;} req_t;
   typedef struct {logic [31:0] a; int due;} mem_t;
   typedef struct {
      bit r, s, p; logic [31:0] t; bit mv; logic [31:0] md;
      bit req; logic [31:0] addr; bit v; logic [31:0] ins, pc, pc4;
   } vec_t;
   req_t q[$];
   mem_t mq[$];
   logic [31:0] m_fpc, m_instr, m_pc, m_pc4;
   bit m_valid;
   bit use_mem;
   int lat, cyc;
   logic [31:0] salt;
   bit obs_req, obs_valid;
   logic [31:0] obs_addr, obs_instr, obs_pc, obs_pc4;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   task automatic m_reset();
      m_fpc = RPC; m_instr = NOP; m_pc = '0; m_pc4 = '0; m_valid = 0;
      q.delete();
   endtask
   task automatic tick(input bit r, input bit s, input bit p, input logic [31:0] t,
                       input bit mv, input logic [31:0] md);
      req_t e;
      bit mreq, cap;
      logic [31:0] mfpc;
      int l, d;
      rst = r; stall = s; PCSrc = p; PCTarget = t;
      if (use_mem) begin
         imem_valid = mq.size() > 0 && mq[0].due == cyc;
         imem_rdata = imem_valid ? (mq[0].a ^ salt) : $urandom;
      end else begin
         imem_valid = mv;
         imem_rdata = md;
      end
      if (r) m_reset();
      #3;
      mreq = !r && q.size() == 0 && !p && !(m_valid && s);
      mfpc = m_fpc;
      obs_req = imem_req; obs_addr = imem_addr; obs_valid = instr_valid;
      obs_instr = instr; obs_pc = pc; obs_pc4 = pc_plus4;
      if (!r) begin
         chk("m_req", imem_req, mreq);
         if (mreq) chk("m_addr", imem_addr, mfpc);
      end
      chk("m_valid", instr_valid, m_valid);
      chk("m_instr", instr, m_instr);
      chk("m_pc", pc, m_pc);
      chk("m_pc4", pc_plus4, m_pc4);
      @(posedge clk);
      #1;
      if (use_mem) begin
         if (imem_valid) void'(mq.pop_front());
         if (obs_req && !r) begin
            l = lat != 0 ? lat : $urandom_range(1, 4);
            d = cyc + l;
            if (mq.size() > 0 && d <= mq[$].due) d = mq[$].due + 1;
            mq.push_back('{obs_addr, d});
         end
      end
      if (!r) begin
         cap = 0;
         if (imem_valid && q.size() > 0) begin
            e = q.pop_front();
            if (!e.stale && !p) begin
               cap = 1;
               m_instr = imem_rdata; m_pc = e.a; m_pc4 = e.a + 32'd4; m_fpc = e.a + 32'd4;
            end
         end
         if (cap) m_valid = 1;
         else if (!s) m_valid = 0;
         if (mreq) q.push_back('{mfpc, 1'b0});
         if (p) begin
            foreach (q[i]) q[i].stale = 1;
            m_fpc = {t[31:2], 2'b00};
            m_valid = 0;
            m_instr = NOP;
         end
      end
      cyc++;
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      vec_t tv[17];
      bit got;
      int n;
      logic [31:0] s_instr, s_pc;
      rst = 1; stall = 0; PCSrc = 0; PCTarget = '0; imem_valid = 0; imem_rdata = '0;
      cyc = 0; use_mem = 0; lat = 1; salt = 32'h1;
      tv[0]  = '{1, 0, 0, 0, 0, 0,                    0, 0, 0, NOP, 0, 0};
      tv[1]  = '{0, 0, 0, 0, 0, 0,                    1, RPC, 0, NOP, 0, 0};
      tv[2]  = '{0, 0, 0, 0, 1, 32'hBFC00001,         0, 0, 0, NOP, 0, 0};
      tv[3]  = '{0, 0, 0, 0, 0, 0,                    1, 32'hBFC00004, 1, 32'hBFC00001, RPC, 32'hBFC00004};
      tv[4]  = '{0, 0, 0, 0, 1, 32'hBFC00005,         0, 0, 0, 32'hBFC00001, RPC, 32'hBFC00004};
      tv[5]  = '{0, 1, 0, 0, 0, 0,                    0, 0, 1, 32'hBFC00005, 32'hBFC00004, 32'hBFC00008};
      tv[6]  = '{0, 0, 0, 0, 0, 0,                    1, 32'hBFC00008, 1, 32'hBFC00005, 32'hBFC00004, 32'hBFC00008};
      tv[7]  = '{0, 0, 1, 32'h103, 1, 32'hBFC00009,   0, 0, 0, 32'hBFC00005, 32'hBFC00004, 32'hBFC00008};
      tv[8]  = '{0, 0, 0, 0, 0, 0,                    1, 32'h100, 0, NOP, 32'hBFC00004, 32'hBFC00008};
      tv[9]  = '{0, 0, 0, 0, 1, 32'h101,              0, 0, 0, NOP, 32'hBFC00004, 32'hBFC00008};
      tv[10] = '{0, 0, 0, 0, 0, 0,                    1, 32'h104, 1, 32'h101, 32'h100, 32'h104};
      tv[11] = '{0, 0, 1, 32'hFFFFFFFE, 0, 0,         0, 0, 0, 32'h101, 32'h100, 32'h104};
      tv[12] = '{0, 0, 0, 0, 0, 0,                    0, 0, 0, NOP, 32'h100, 32'h104};
      tv[13] = '{0, 0, 0, 0, 1, 32'h105,              0, 0, 0, NOP, 32'h100, 32'h104};
      tv[14] = '{0, 0, 0, 0, 0, 0,                    1, 32'hFFFFFFFC, 0, NOP, 32'h100, 32'h104};
      tv[15] = '{0, 0, 0, 0, 1, 32'h12345678,         0, 0, 0, NOP, 32'h100, 32'h104};
      tv[16] = '{0, 0, 0, 0, 0, 0,                    1, 32'h0, 1, 32'h12345678, 32'hFFFFFFFC, 32'h0};
      for (int i = 0; i < 17; i++) begin
         tick(tv[i].r, tv[i].s, tv[i].p, tv[i].t, tv[i].mv, tv[i].md);
         if (!tv[i].r) chk($sformatf("tv%0d_req", i), obs_req, tv[i].req);
         if (tv[i].req) chk($sformatf("tv%0d_addr", i), obs_addr, tv[i].addr);
         chk($sformatf("tv%0d_valid", i), obs_valid, tv[i].v);
         chk($sformatf("tv%0d_instr", i), obs_instr, tv[i].ins);
         chk($sformatf("tv%0d_pc", i), obs_pc, tv[i].pc);
         chk($sformatf("tv%0d_pc4", i), obs_pc4, tv[i].pc4);
      end
      use_mem = 1; lat = 3; salt = 32'h1; mq.delete();
      tick(1, 0, 0, 0, 0, 0);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick(0, 1, 0, 0, 0, 0);
         if (obs_valid) got = 1;
      end
      chk("stall_wait", got, 1);
      s_instr = obs_instr; s_pc = obs_pc;
      chk("stall_first_pc", s_pc, RPC);
      for (int i = 0; i < 5; i++) begin
         tick(0, 1, 0, 0, 0, 0);
         chk("stall_instr", obs_instr, s_instr);
         chk("stall_pc", obs_pc, s_pc);
         chk("stall_req", obs_req, 0);
         chk("stall_valid", obs_valid, 1);
      end
      n = 0;
      for (int i = 0; i < 4; i++) begin
         tick(0, 0, 0, 0, 0, 0);
         if (obs_req) begin
            n++;
            chk("release_addr", obs_addr, s_pc + 32'd4);
         end
      end
      chk("release_count", n, 1);
      mq.delete();
      tick(1, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0);
      chk("redir_first_req", obs_req, 1);
      tick(0, 0, 1, 32'h103, 0, 0);
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick(0, 0, 0, 0, 0, 0);
         if (obs_req) begin
            got = 1;
            chk("redir_addr", obs_addr, 32'h100);
         end else chk("redir_valid", obs_valid, 0);
      end
      chk("redir_wait", got, 1);
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick(0, 0, 0, 0, 0, 0);
         if (obs_valid) begin
            got = 1;
            chk("redir_pc", obs_pc, 32'h100);
            chk("redir_instr", obs_instr, 32'h101);
         end
      end
      chk("redir_cap_wait", got, 1);
      lat = 2; mq.delete();
      tick(1, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0);
      chk("rstbusy_req", obs_req, 1);
      tick(1, 0, 0, 0, 0, 0);
      tick(0, 0, 0, 0, 0, 0);
      chk("rstbusy_stale_arrives", imem_valid, 1);
      chk("rstbusy_req_after", obs_req, 1);
      chk("rstbusy_addr_after", obs_addr, RPC);
      chk("rstbusy_valid0", obs_valid, 0);
      tick(0, 0, 0, 0, 0, 0);
      chk("rstbusy_valid1", obs_valid, 0);
      tick(0, 0, 0, 0, 0, 0);
      tick(0, 1, 0, 0, 0, 0);
      chk("rstbusy_cap_valid", obs_valid, 1);
      chk("rstbusy_cap_pc", obs_pc, RPC);
      chk("rstbusy_cap_instr", obs_instr, RPC ^ 32'h1);
      lat = 0; salt = $urandom; mq.delete();
      tick(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         tick(0, $urandom_range(0, 9) < 3, $urandom_range(0, 15) == 0,
              ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom, 0, 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that sits directly upstream of the decode stage (control unit, register file, sign extension). It owns the program counter and issues one request at a time to an instruction memory with variable response latency. It holds the fetched word, its PC and PC+4 in an output register for decode. Taken branches and jumps (PCSrc from control, PCTarget from execute) redirect the PC and kill any in-flight fetch.

## Interface
Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instruction words
- RESET_PC, 32'hBFC00000, first fetch address after reset

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  decode cannot accept; output register holds
- PCSrc  in  1  redirect request (taken branch/jump); acts as flush
- PCTarget  in  DATA_WIDTH  redirect address; bits [1:0] ignored (forced 0)
- imem_req  out  1  request strobe; accepted by memory in the same cycle
- imem_addr  out  DATA_WIDTH  request address (word aligned)
- imem_valid  in  1  response strobe; at least 1 cycle after the request, in order
- imem_rdata  in  DATA_WIDTH  response word, qualified by imem_valid
- instr  out  DATA_WIDTH  instruction to decode
- pc  out  DATA_WIDTH  address of instr
- pc_plus4  out  DATA_WIDTH  pc + 4
- instr_valid  out  1  output register holds a live instruction

## Operation
- Registers: fetch_pc, the next/outstanding address; state; output register {instr, pc, pc_plus4, instr_valid}.
- States:
  - IDLE: nothing outstanding.
  - BUSY: one request outstanding, response wanted.
  - DROP: one request outstanding, response stale.
- imem_req = (state==IDLE) && !PCSrc && !(instr_valid && stall). imem_addr = fetch_pc, always driven.
- Consume: decode takes the output when instr_valid && !stall. instr_valid clears on consume unless it is set the same cycle.
- Transitions:
  - IDLE & imem_req -> BUSY.
  - BUSY & imem_valid & !PCSrc -> IDLE. Capture: instr <= imem_rdata, pc <= fetch_pc, pc_plus4 <= fetch_pc+4, instr_valid <= 1, fetch_pc <= fetch_pc+4.
  - BUSY & PCSrc & !imem_valid -> DROP.
  - BUSY & PCSrc & imem_valid -> IDLE. Response discarded.
  - DROP & imem_valid -> IDLE. Response discarded.
  - DROP & PCSrc & !imem_valid -> DROP. fetch_pc is updated.
- Any PCSrc, in any state:
  - fetch_pc <= {PCTarget[DW-1:2],2'b00}
  - instr_valid <= 0
  - instr <= 32'h00000013 (NOP)
  - pc and pc_plus4 hold
  - PCSrc overrides stall.
- imem_valid is ignored in IDLE (covers responses that arrive after a mid-flight reset).
- Only one request is ever outstanding. A capture only happens when the output register is empty, because the previous entry was consumed before the request was issued. No overwrite is possible.
- Address arithmetic is modulo 2^DATA_WIDTH: 32'hFFFFFFFC + 4 wraps to 0.

## Timing
- Reset values:
  - state=IDLE
  - fetch_pc=RESET_PC
  - instr=32'h00000013
  - pc=0, pc_plus4=0
  - instr_valid=0
  - imem_req rises the first cycle after rst deasserts.
- Latency: with memory latency L (>=1), a request issued in cycle t is captured at the edge ending cycle t+L. instr_valid is high from cycle t+L+1.
- Throughput: one instruction per L+1 cycles when stall is low. The next request issues in the cycle after capture.
- Redirect: PCSrc in cycle t means the first request to the target issues in cycle t+1 if state was IDLE. Otherwise it issues the cycle after the stale response returns.
- Stall with instr_valid=1: no new request issues, and the outputs are stable every cycle.

## Test plan
- Reset, memory L=1 returning addr^32'h1: imem_req at cycle 1 with addr BFC00000; instr=BFC00001, pc=BFC00000, pc_plus4=BFC00004 valid at cycle 3; next addr BFC00004 at cycle 3.
- L=3, stall high for 5 cycles while instr_valid=1: outputs unchanged, imem_req=0 throughout; after release, exactly one request to the next sequential address.
- PCSrc=1 with PCTarget=32'h00000103 while BUSY (L=3): stale response dropped, instr_valid stays 0, next imem_addr=32'h00000100, captured pc=32'h00000100.
- PCSrc coincident with imem_valid in BUSY: word discarded, instr=00000013, instr_valid=0, next request to the target.
- rst asserted while BUSY, response arrives 1 cycle after release: ignored; first request is to BFC00000, no spurious instr_valid.
- fetch_pc=FFFFFFFC: captured pc_plus4=0, next imem_addr=0.
